spi_frame_reader: RTL and testbench

- SPI master for the image readout link; the opposite end of the SPI slave that streams captured frame data out on miso.
- Waits for the slave side's spi_start strobe, then generates spi_clk and samples miso MSB-first.
- Assembles WORD_W-bit words and hands them downstream on a valid/ready interface.
- Stops after FRAME_WORDS words and pulses frame_done.
- Used as the host-side model/bridge and as the loopback checker for the capture-to-SPI path.

---
 rtl/spi_frame_reader.sv | 168 ++++++++++++++++
 tb/tb_spi_frame_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_reader.sv
// spi_frame_reader: host-side SPI mode-0 master for the image readout link.
// Arms on a spi_start rising edge, clocks miso in MSB-first, and delivers
// WORD_W-bit words on a valid/ready port until FRAME_WORDS are accepted.
// Optional per-frame word checksum on frame_sum, enabled by SPI_FRAME_SUM_EN.
module spi_frame_reader #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned FRAME_WORDS = 153600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_start,
  input  logic              miso,
  output logic              spi_clk,
  output logic              busy,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [17:0]       word_count,
  output logic              frame_done,
  output logic [31:0]       frame_sum
);

  localparam int unsigned      BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [7:0]       PH_LAST   = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(WORD_W - 1);
  localparam logic [17:0]      LAST_WORD = 18'(FRAME_WORDS) - 18'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t            state;
  logic              start_q;
  logic              start_rise;
  logic [7:0]        phase;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              word_end;
  logic [17:0]       rx_words;
  logic              rx_done;
  logic              accept;
  logic              last_accept;
  logic              stall;

  assign start_rise  = spi_start & ~start_q;
  assign accept      = word_valid & word_ready;
  assign last_accept = accept && (word_count == LAST_WORD);
  // rx_done parks the clock in LOW once the frame's final bit is in, so no
  // rising edge is issued while the last word waits for acceptance.
  assign stall       = (word_valid & ~word_ready) | rx_done;

  // Sequencer: start edge detect, spi_clk phases, bit shifting, word handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      phase      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_end   <= 1'b0;
      rx_words   <= '0;
      rx_done    <= 1'b0;
      spi_clk    <= 1'b0;
      busy       <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
      frame_done <= 1'b0;
    end else begin
      start_q    <= spi_start;
      frame_done <= 1'b0;
      word_end   <= 1'b0;

      if (accept) begin
        word_valid <= 1'b0;
        word_count <= word_count + 18'd1;
      end

      if (word_end) begin
        word_data  <= shreg;
        word_valid <= 1'b1;
        bit_cnt    <= BIT_TOP;
      end

      case (state)
        IDLE: begin
          spi_clk <= 1'b0;
          if (start_rise) begin
            state      <= LOW;
            busy       <= 1'b1;
            word_count <= '0;
            bit_cnt    <= BIT_TOP;
            phase      <= '0;
            shreg      <= '0;
            rx_words   <= '0;
            rx_done    <= 1'b0;
          end
        end
        LOW: begin
          if (!stall) begin
            if (phase == PH_LAST) begin
              state   <= HIGH;
              spi_clk <= 1'b1;
              phase   <= '0;
            end else begin
              phase <= phase + 8'd1;
            end
          end
        end
        HIGH: begin
          if (phase == '0) begin
            shreg <= (shreg << 1) | WORD_W'(miso);
            if (bit_cnt == '0) begin
              word_end <= 1'b1;
              rx_words <= rx_words + 18'd1;
              if (rx_words == LAST_WORD) rx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          if (phase == PH_LAST) begin
            state   <= LOW;
            spi_clk <= 1'b0;
            phase   <= '0;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          spi_clk <= 1'b0;
        end
      endcase

      if (last_accept) begin
        state      <= IDLE;
        spi_clk    <= 1'b0;
        busy       <= 1'b0;
        frame_done <= 1'b1;
        phase      <= '0;
        rx_done    <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_SUM_EN
  logic [31:0] sum_acc;

  // Checksum: modulo-2^32 sum of accepted words, cleared on arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc <= '0;
    end else if (state == IDLE && start_rise) begin
      sum_acc <= '0;
    end else if (accept) begin
      sum_acc <= sum_acc + 32'(word_data);
    end
  end

  assign frame_sum = sum_acc;
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_spi_frame_reader.sv
// Testbench for spi_frame_reader: reset/idle vector table, directed frames
// (single pattern, backpressure, start-edge rules, mid-frame reset, checksum)
// and randomized frames checked against a word-queue slave/scoreboard model.
module tb_spi_frame_reader;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned FRAME_WORDS = 3;

  logic        clk;
  logic        rst;
  logic        spi_start;
  logic        miso;
  logic        spi_clk;
  logic        busy;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [17:0] word_count;
  logic        frame_done;
  logic [31:0] frame_sum;

  spi_frame_reader #(
    .CLK_DIV    (CLK_DIV),
    .WORD_W     (WORD_W),
    .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_start (spi_start),
    .miso      (miso),
    .spi_clk   (spi_clk),
    .busy      (busy),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_count(word_count),
    .frame_done(frame_done),
    .frame_sum (frame_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bits the slave still has to shift, words the
  // host still expects, and per-frame bookkeeping.
  bit          slave_bits[$];
  logic [31:0] exp_words[$];
  int          acc_count   = 0;
  logic [31:0] exp_sum     = '0;
  int          sclk_rises  = 0;
  int          last_rise   = -1;
  int          cycle       = 0;
  bit          check_period = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_words.push_back(w);
    for (int i = 31; i >= 0; i--) slave_bits.push_back(w[i]);
  endtask

  // One clock cycle: scoreboard acceptance, protocol checks, slave shifting.
  task automatic tick();
    logic acc_pre, stall_pre, sclk_pre, done_exp;
    logic [31:0] data_pre, ew;
    acc_pre   = word_valid && word_ready;
    stall_pre = word_valid && !word_ready;
    sclk_pre  = spi_clk;
    data_pre  = word_data;
    if (acc_pre) begin
      if (exp_words.size() == 0) begin
        check("extra_word", word_valid, 1'b0);
      end else begin
        ew = exp_words.pop_front();
        check("word_data", word_data, ew);
        exp_sum = exp_sum + ew;
      end
      acc_count++;
    end
    @(posedge clk);
    #1;
    cycle++;
    done_exp = acc_pre && (acc_count == FRAME_WORDS);
    if (done_exp || frame_done) begin
      check("frame_done", frame_done, done_exp);
      if (done_exp) begin
        check("done_busy", busy, 1'b0);
        check("done_word_count", word_count, FRAME_WORDS);
        check("done_sclk_pulses", sclk_rises, FRAME_WORDS * WORD_W);
        check("done_no_pending_words", exp_words.size(), 0);
`ifdef SPI_FRAME_SUM_EN
        check("frame_sum", frame_sum, exp_sum);
`else
        check("frame_sum_off", frame_sum, 32'h0);
`endif
      end
    end
    if (acc_pre) check("valid_clears", word_valid, 1'b0);
    if (stall_pre && word_valid) check("data_stable", word_data, data_pre);
    if (!sclk_pre && spi_clk) begin
      check("no_rise_while_stalled", stall_pre, 1'b0);
      if (check_period && last_rise >= 0) check("sclk_period", cycle - last_rise, 2 * CLK_DIV);
      last_rise = cycle;
      sclk_rises++;
    end
    if (sclk_pre && !spi_clk) miso = (slave_bits.size() != 0) ? slave_bits.pop_front() : 1'b0;
  endtask

  task automatic arm();
    miso       = (slave_bits.size() != 0) ? slave_bits.pop_front() : 1'b0;
    acc_count  = 0;
    exp_sum    = '0;
    sclk_rises = 0;
    last_rise  = -1;
    spi_start  = 1'b1;
    tick();
    check("arm_busy", busy, 1'b1);
    check("arm_word_count", word_count, 18'd0);
    spi_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin
      tick();
      n++;
    end
    if (!frame_done) check("frame_done_timeout", frame_done, 1'b1);
  endtask

  typedef struct {
    logic rst;
    logic start;
    logic miso;
    logic ready;
    logic [3:0] exp_flags;   // {spi_clk, busy, word_valid, frame_done}
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[10];
    int   n;
    bit   bad;

    rst = 1'b1; spi_start = 1'b0; miso = 1'b0; word_ready = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0100};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0100};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst; spi_start = vecs[i].start; miso = vecs[i].miso; word_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_flags", i), {spi_clk, busy, word_valid, frame_done}, vecs[i].exp_flags);
      if (!busy) check($sformatf("vec%0d_word_count", i), word_count, 18'd0);
    end
    spi_start = 1'b0; miso = 1'b0;
    tick();

    // Known pattern, no backpressure: period, pulse count, latency.
    word_ready = 1'b1;
    check_period = 1'b1;
    push_word(32'hA5C3_0F81);
    push_word($urandom);
    push_word($urandom);
    arm();
    wait_done(2000);
    check_period = 1'b0;
    repeat (4) tick();

    // Backpressure on the first word.
    word_ready = 1'b0;
    push_word($urandom);
    push_word($urandom);
    push_word($urandom);
    arm();
    n = 0;
    while (!word_valid && n < 500) begin tick(); n++; end
    check("bp_first_valid", word_valid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("bp_sclk_low", spi_clk, 1'b0);
      check("bp_data_hold", word_data, exp_words[0]);
      tick();
    end
    word_ready = 1'b1;
    wait_done(2000);

    // Extra spi_start pulses mid-frame are ignored.
    push_word($urandom);
    push_word($urandom);
    push_word($urandom);
    arm();
    repeat (30) tick();
    spi_start = 1'b1; repeat (3) tick();
    spi_start = 1'b0; repeat (3) tick();
    spi_start = 1'b1; repeat (3) tick();
    spi_start = 1'b0;
    check("pulse_busy_held", busy, 1'b1);
    wait_done(2000);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy || word_valid || spi_clk) bad = 1'b1;
    end
    check("idle_after_frame", bad, 1'b0);
    check("count_holds", word_count, FRAME_WORDS);

    // Reset after 10 bits, then a clean frame.
    push_word($urandom);
    push_word($urandom);
    push_word($urandom);
    arm();
    n = 0;
    while (sclk_rises < 10 && n < 500) begin tick(); n++; end
    check("rst_reached_10_bits", sclk_rises, 10);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    slave_bits.delete();
    exp_words.delete();
    miso = 1'b0;
    check("rst_flags", {spi_clk, busy, word_valid, frame_done}, 4'b0000);
    check("rst_word_count", word_count, 18'd0);
    check("rst_word_data", word_data, 32'h0);
    check("rst_frame_sum", frame_sum, 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (word_valid || frame_done || busy || spi_clk) bad = 1'b1;
    end
    check("rst_stays_idle", bad, 1'b0);
    push_word($urandom);
    push_word($urandom);
    push_word($urandom);
    arm();
    wait_done(2000);

    // Checksum wrap pattern: sum is 0x1000_0001.
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0002);
    push_word(32'h1000_0000);
    arm();
    wait_done(2000);
`ifdef SPI_FRAME_SUM_EN
    check("sum_pattern", frame_sum, 32'h1000_0001);
`endif

    // Randomized frames with random backpressure.
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < int'(FRAME_WORDS); w++) push_word($urandom);
      word_ready = 1'b1;
      arm();
      n = 0;
      while (!frame_done && n < 4000) begin
        word_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      if (!frame_done) check("rand_frame_timeout", frame_done, 1'b1);
      word_ready = 1'b1;
      repeat ($urandom_range(1, 6)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
